// File: rtl/snake_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_ctrl_pkg
// Purpose  : Shared encodings for the snake game sequencer: game states,
//            direction codes, lower-case key codes and the UART key decoder.
// Revision : 1.0 - initial release
// ============================================================================
package snake_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DEAD  = 2'd3
  } game_state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Lower-case ASCII; upper-case input folds onto these by OR-ing bit 5.
  localparam logic [7:0] KEY_UP      = 8'h77;  // 'w'
  localparam logic [7:0] KEY_RIGHT   = 8'h64;  // 'd'
  localparam logic [7:0] KEY_DOWN    = 8'h73;  // 's'
  localparam logic [7:0] KEY_LEFT    = 8'h61;  // 'a'
  localparam logic [7:0] KEY_PAUSE   = 8'h20;  // ' '
  localparam logic [7:0] KEY_RESTART = 8'h72;  // 'r'

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_DIR     = 2'd1,
    CMD_PAUSE   = 2'd2,
    CMD_RESTART = 2'd3
  } key_cmd_e;

  typedef struct packed {
    key_cmd_e   cmd;
    logic [1:0] dir;
  } key_cmd_t;

  // Case-insensitive decode of one received byte into a game command.
  function automatic key_cmd_t decode_key(input logic [7:0] raw);
    logic [7:0] key;
    key_cmd_t   c;
    key   = raw | 8'h20;
    c.cmd = CMD_NONE;
    c.dir = DIR_RIGHT;
    case (key)
      KEY_UP:      begin c.cmd = CMD_DIR; c.dir = DIR_UP;    end
      KEY_RIGHT:   begin c.cmd = CMD_DIR; c.dir = DIR_RIGHT; end
      KEY_DOWN:    begin c.cmd = CMD_DIR; c.dir = DIR_DOWN;  end
      KEY_LEFT:    begin c.cmd = CMD_DIR; c.dir = DIR_LEFT;  end
      KEY_PAUSE:   c.cmd = CMD_PAUSE;
      KEY_RESTART: c.cmd = CMD_RESTART;
      default:     c.cmd = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_game_ctrl_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_ctrl_step_timer
// Purpose  : Step pacing counter. Counts enabled cycles and emits a 1-cycle
//            tick when the count reaches period-1, then wraps to zero.
//            Holds while disabled; clear forces the count to zero.
// Revision : 1.0 - initial release
// ============================================================================
module snake_game_ctrl_step_timer #(
  parameter int CNT_W = 3,
  parameter int PER_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = en && (PER_W'(count_q) == (period - PER_W'(1)));

  // Next count: clear wins, otherwise advance or wrap while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_ctrl
// Purpose  : Snake game sequencer. Decodes UART keys into direction, pause
//            and restart commands, paces snake moves with a speeding-up step
//            timer, handshakes steps with the body datapath and keeps score.
// Revision : 1.0 - initial release
// ============================================================================
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 2500000,
  parameter int MIN_DIV  = 500000,
  parameter int SPEEDUP  = 100000,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         dataRX,
  input  logic               WR_RX,
  input  logic               step_ack,
  input  logic               collision,
  input  logic               food_eaten,
  output logic               step_req,
  output logic [1:0]         dir,
  output logic               clear_req,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score
);

  localparam int TIMER_W  = $clog2(STEP_DIV);
  localparam int PERIOD_W = $clog2(STEP_DIV + 1);
  localparam logic [PERIOD_W-1:0] PERIOD_RESET = PERIOD_W'(STEP_DIV);

  if (STEP_DIV < MIN_DIV || MIN_DIV < 2) begin : g_param_check
    $error("snake_game_ctrl: need STEP_DIV >= MIN_DIV >= 2");
  end

  game_state_e         state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [1:0]          pend_dir_q, pend_dir_d;
  logic                step_req_q, step_req_d;
  logic                clear_req_q, clear_req_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [PERIOD_W-1:0] period_q, period_d;

  game_state_e         st_eff;
  logic                timer_en;
  logic                timer_clr;
  logic                timer_tick;
  key_cmd_t            key_cmd;

  assign key_cmd  = decode_key(dataRX);
  // The step timer only runs while playing with no move in flight.
  assign timer_en = (state_q == ST_RUN) && !step_req_q;

  snake_game_ctrl_step_timer #(
    .CNT_W (TIMER_W),
    .PER_W (PERIOD_W)
  ) u_step_timer (
    .clk    (clk),
    .rstn   (rstn),
    .en     (timer_en),
    .clr    (timer_clr),
    .period (period_q),
    .tick   (timer_tick)
  );

  // Game FSM: restart overrides everything; otherwise the step result is
  // applied first so a collision makes any same-cycle key act in DEAD.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pend_dir_d  = pend_dir_q;
    step_req_d  = step_req_q;
    clear_req_d = 1'b0;
    score_d     = score_q;
    period_d    = period_q;
    timer_clr   = 1'b0;
    st_eff      = state_q;

    if (WR_RX && key_cmd.cmd == CMD_RESTART) begin
      state_d     = ST_IDLE;
      dir_d       = DIR_RIGHT;
      pend_dir_d  = DIR_RIGHT;
      step_req_d  = 1'b0;
      clear_req_d = 1'b1;
      score_d     = '0;
      period_d    = PERIOD_RESET;
      timer_clr   = 1'b1;
    end else begin
      // Direction is committed on the rising edge of the request.
      if (timer_tick) begin
        step_req_d = 1'b1;
        dir_d      = pend_dir_q;
      end

      if (step_ack && step_req_q) begin
        step_req_d = 1'b0;
        if (collision) begin
          st_eff = ST_DEAD;
        end else if (food_eaten) begin
          if (score_q != '1) begin
            score_d = score_q + SCORE_W'(1);
          end
          if (32'(period_q) >= 32'(MIN_DIV + SPEEDUP)) begin
            period_d = period_q - PERIOD_W'(SPEEDUP);
          end else begin
            period_d = PERIOD_W'(MIN_DIV);
          end
        end
      end

      if (WR_RX && st_eff != ST_DEAD) begin
        case (key_cmd.cmd)
          CMD_DIR: begin
            // A direct reversal would run the head into the body: drop it.
            if (key_cmd.dir != (dir_q ^ 2'b10)) begin
              pend_dir_d = key_cmd.dir;
            end
            if (st_eff == ST_IDLE) begin
              st_eff    = ST_RUN;
              timer_clr = 1'b1;
            end
          end
          CMD_PAUSE: begin
            if (st_eff == ST_RUN) begin
              st_eff = ST_PAUSE;
            end else if (st_eff == ST_PAUSE) begin
              st_eff = ST_RUN;
            end
          end
          default: ;
        endcase
      end

      state_d = st_eff;
    end
  end

  // Game state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      pend_dir_q  <= DIR_RIGHT;
      step_req_q  <= 1'b0;
      clear_req_q <= 1'b0;
      score_q     <= '0;
      period_q    <= PERIOD_RESET;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_dir_q  <= pend_dir_d;
      step_req_q  <= step_req_d;
      clear_req_q <= clear_req_d;
      score_q     <= score_d;
      period_q    <= period_d;
    end
  end

  assign step_req  = step_req_q;
  assign dir       = dir_q;
  assign clear_req = clear_req_q;
  assign state     = state_q;
  assign score     = score_q;

endmodule
`default_nettype wire
